// File: rtl/maxpool2d_stream_pkg.sv
// rtl/maxpool2d_stream_pkg.sv - shared defaults and sizing helpers for the 2x2 max-pool stage
//
// Default geometry, activation width and derivation functions used by
// maxpool2d_stream and its per-channel max helper.
package maxpool2d_stream_pkg;

    localparam int DEF_IN_WIDTH   = 32;
    localparam int DEF_IN_HEIGHT  = 32;
    localparam int DEF_NUM_CH     = 32;
    localparam int DEF_ACTIV_BITS = 8;

    // Pooled dimension (OUT_WIDTH / OUT_HEIGHT) for a given input dimension.
    function automatic int out_dim(input int n);
        return n / 2;
    endfunction

    // Packed pixel width (PIX_BITS) for all channels of one pixel.
    function automatic int pix_bits(input int num_ch, input int activ_bits);
        return num_ch * activ_bits;
    endfunction

    // Counter/index width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool2d_stream_vec_max.sv
// rtl/maxpool2d_stream_vec_max.sv - combinational per-channel unsigned max of two packed pixels
//
// Ports:
//   a_i   [NUM_CH*ACTIV_BITS]  first packed pixel
//   b_i   [NUM_CH*ACTIV_BITS]  second packed pixel
//   max_o [NUM_CH*ACTIV_BITS]  channel-wise max, same packing
module maxpool2d_stream_vec_max
    import maxpool2d_stream_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ACTIV_BITS = DEF_ACTIV_BITS
) (
    input  logic [pix_bits(NUM_CH, ACTIV_BITS)-1:0] a_i,
    input  logic [pix_bits(NUM_CH, ACTIV_BITS)-1:0] b_i,
    output logic [pix_bits(NUM_CH, ACTIV_BITS)-1:0] max_o
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign max_o[k*ACTIV_BITS +: ACTIV_BITS] =
            (a_i[k*ACTIV_BITS +: ACTIV_BITS] >= b_i[k*ACTIV_BITS +: ACTIV_BITS])
            ? a_i[k*ACTIV_BITS +: ACTIV_BITS]
            : b_i[k*ACTIV_BITS +: ACTIV_BITS];
    end

endmodule

// File: rtl/maxpool2d_stream.sv
// rtl/maxpool2d_stream.sv - streaming 2x2 stride-2 max pooling with a half-width line buffer
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   clear             synchronous frame abort/realign (wins over an accept)
//   in_valid/in_ready upstream pixel handshake, row-major order
//   in_data           packed pixel, channel k at [k*ACTIV_BITS +: ACTIV_BITS]
//   out_valid/out_ready downstream pooled-pixel handshake
//   out_data          pooled pixel, same packing as in_data
//   out_last          marks the final pooled pixel of a frame
module maxpool2d_stream
    import maxpool2d_stream_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int IN_HEIGHT  = DEF_IN_HEIGHT,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ACTIV_BITS = DEF_ACTIV_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clear,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [pix_bits(NUM_CH, ACTIV_BITS)-1:0] in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [pix_bits(NUM_CH, ACTIV_BITS)-1:0] out_data,
    output logic                                    out_last
);

    localparam int PIX_BITS  = pix_bits(NUM_CH, ACTIV_BITS);
    localparam int OUT_WIDTH = out_dim(IN_WIDTH);
    localparam int COL_W     = cnt_width(IN_WIDTH);
    localparam int ROW_W     = cnt_width(IN_HEIGHT);
    localparam int LB_AW     = cnt_width(OUT_WIDTH);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IN_HEIGHT - 1);

    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PIX_BITS-1:0] h_q, h_d;
    logic [PIX_BITS-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    // One horizontally pooled pair per output column; holds the even row
    // until the odd row below it arrives.
    logic [PIX_BITS-1:0] linebuf_q [OUT_WIDTH];

    logic [PIX_BITS-1:0] h_max, v_max, lb_rd;
    logic [LB_AW-1:0]    lb_idx;
    logic                accept, col_end, row_end, lb_we;

    // Lossless but conservative: a new pixel may only complete a window if
    // the output register is free or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col_q == COL_MAX);
    assign row_end  = (row_q == ROW_MAX);
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = linebuf_q[lb_idx];
    assign lb_we    = accept && !clear && col_q[0] && !row_q[0];

    maxpool2d_stream_vec_max #(
        .NUM_CH     (NUM_CH),
        .ACTIV_BITS (ACTIV_BITS)
    ) u_hmax (
        .a_i   (h_q),
        .b_i   (in_data),
        .max_o (h_max)
    );

    maxpool2d_stream_vec_max #(
        .NUM_CH     (NUM_CH),
        .ACTIV_BITS (ACTIV_BITS)
    ) u_vmax (
        .a_i   (lb_rd),
        .b_i   (h_max),
        .max_o (v_max)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        h_d         = h_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                h_d = in_data;
            end else if (row_q[0]) begin
                // Bottom-right pixel of a window: the output slot is known
                // free here because accept implies in_ready.
                out_data_d  = v_max;
                out_valid_d = 1'b1;
                out_last_d  = row_end && col_end;
            end
        end

        if (clear) begin
            col_d       = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            h_q         <= h_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it,
    // so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= h_max;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/maxpool2d_stream.md
Name: maxpool2d_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of conv2d in the keyword-spotting feature pipeline.
- Accepts one post-ReLU feature-map pixel per handshake, carrying all NUM_CH filter channels packed, in row-major order.
- Emits one pooled pixel per 2x2 window with a valid/ready handshake.
- Uses a half-width line buffer, so a full frame is never stored.

Parameters:
- IN_WIDTH, 32, feature-map width in pixels; even, >= 2.
- IN_HEIGHT, 32, feature-map height in pixels; even, >= 2.
- NUM_CH, 32, channels (filters) per pixel.
- ACTIV_BITS, 8, bits per channel value; unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous frame abort/realign
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- in_data  in  NUM_CH*ACTIV_BITS  pixel; channel k at [k*ACTIV_BITS +: ACTIV_BITS]
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_CH*ACTIV_BITS  pooled pixel; same channel packing as in_data
- out_last  out  1  high with the final pooled pixel of a frame

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- Reset values:
  - out_valid=0, out_data=0, out_last=0.
  - col=0, row=0, h_reg=0.
  - Line buffer contents are not reset; every entry is written before it is read.
- Accept: an input is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational). This is conservative but lossless.
- Counters:
  - On each accept, col increments; at IN_WIDTH-1, col wraps to 0 and row increments.
  - At (IN_HEIGHT-1, IN_WIDTH-1), both wrap to 0 and the next frame starts with no idle cycle.
- Horizontal stage:
  - Even col: h_reg <= in_data.
  - Odd col: hmax = per-channel unsigned max(h_reg, in_data).
- Vertical stage:
  - Even row, odd col: linebuf[col>>1] <= hmax.
  - Odd row, odd col: out_data <= per-channel max(linebuf[col>>1], hmax); out_valid <= 1; out_last <= (row==IN_HEIGHT-1 && col==IN_WIDTH-1).
- Latency: out_valid rises on the clock edge that accepts the bottom-right pixel of a window, so data is visible the next cycle.
- Output hold: out_data and out_last are held stable while out_valid && !out_ready. out_valid clears on out_ready unless a new window completes in the same cycle. That case is back-to-back and legal because in_ready is high when out_ready is high.
- Ties: equal values yield that value. Max is exact; no arithmetic widening is needed.
- clear:
  - Forces col=0, row=0, out_valid=0, out_last=0.
  - Has priority over a simultaneous accept; that pixel is dropped.
  - A pending output is discarded.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0).
- Output count: exactly (IN_WIDTH/2)*(IN_HEIGHT/2) outputs per frame, in row-major pooled order.

Decomposition:
- Shared package holds:
  - ACTIV_BITS default.
  - Derived constants OUT_WIDTH=IN_WIDTH/2, OUT_HEIGHT=IN_HEIGHT/2, PIX_BITS=NUM_CH*ACTIV_BITS.
  - Counter width function (clog2).
- One sub-module, vec_max: purely combinational per-channel unsigned max of two packed NUM_CH*ACTIV_BITS vectors. It is instantiated twice (horizontal and vertical).
- Counters, line buffer, h_reg and the output register stay in maxpool2d_stream.

Test Plan:
- Bench parameters: IN_WIDTH=4, IN_HEIGHT=4, NUM_CH=2.
- Basic pooling:
  - Stimulus: ch0 = 4*row+col, ch1 = 15-(4*row+col); valid every cycle, out_ready=1.
  - Required: outputs ch0 = 5,7,13,15 and ch1 = 15,13,7,5; out_last only on the 4th output; each output one cycle after the odd-row odd-col accept.
- Backpressure:
  - Stimulus: same frame, out_ready=0 for 5 cycles when the first output appears.
  - Required: in_ready=0 throughout; out_data stable at (5,15); after release, all 4 outputs correct with no loss or duplication.
- Saturation and ties:
  - Stimulus: all channels 0xFF, then a frame of all 0x00.
  - Required: 4 outputs of 0xFFFF, then 4 outputs of 0x0000.
- Reset mid-frame:
  - Stimulus: rst_n low after 6 pixels, then a full fresh frame.
  - Required: out_valid=0 during reset; exactly 4 correct outputs for the fresh frame, nothing from the partial frame.
- clear with accept:
  - Stimulus: clear=1 and in_valid=1 in the same cycle mid-frame, then 16 pixels.
  - Required: the coincident pixel is dropped; the subsequent 16 produce 4 correct outputs with out_last on the 4th.
- Back-to-back frames:
  - Stimulus: two frames streamed with continuous in_valid.
  - Required: 8 outputs; out_last on the 4th and 8th; frame-2 values correct.
